// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with capture-time WB bypass, EX-side operand
// forwarding from EX/MEM and MEM/WB, and load-use hazard detection.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  // decoded instruction from ID
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_rs_val,
  input  logic [31:0] id_rt_val,
  input  logic [31:0] id_imm,
  input  logic        id_use_imm,
  input  logic        id_use_rt,
  input  logic [2:0]  id_alu_op,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  // pipeline control
  input  logic        flush,
  input  logic        ex_hold,
  // forwarding sources
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_result,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_result,
  // EX-side view
  output logic        ex_valid,
  output logic [2:0]  ex_alu_op,
  output logic [31:0] ex_data1,
  output logic [31:0] ex_data2,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        stall_out
);

  typedef enum logic [1:0] {
    ACT_LOAD,
    ACT_BUBBLE,
    ACT_HOLD,
    ACT_FLUSH
  } act_e;

  logic        r_valid;
  logic [4:0]  r_rs;
  logic [4:0]  r_rt;
  logic [4:0]  r_rd;
  logic [31:0] r_rs_val;
  logic [31:0] r_rt_val;
  logic [31:0] r_imm;
  logic        r_use_imm;
  logic [2:0]  r_alu_op;
  logic        r_reg_write;
  logic        r_mem_read;
  logic        r_mem_write;

  act_e        w_act;
  logic        w_hazard;
  logic [31:0] w_rs_cap;
  logic [31:0] w_rt_cap;
  logic [31:0] w_fwd_rs;
  logic [31:0] w_fwd_rt;

  // Load-use detection, edge action priority and stall request
  always_comb begin
    w_hazard = r_valid && r_mem_read && (r_rd != '0) && id_valid &&
               ((id_rs == r_rd) || (id_use_rt && (id_rt == r_rd)));
    if (flush)         w_act = ACT_FLUSH;
    else if (ex_hold)  w_act = ACT_HOLD;
    else if (w_hazard) w_act = ACT_BUBBLE;
    else               w_act = ACT_LOAD;
    stall_out = !flush && (w_hazard || ex_hold);
  end

  // Register-file write in WB is not yet visible to ID; bypass it at capture
  always_comb begin
    w_rs_cap = id_rs_val;
    w_rt_cap = id_rt_val;
    if (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs)) w_rs_cap = wb_result;
    if (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rt)) w_rt_cap = wb_result;
  end

  // Pipeline register update; flush and bubble only kill valid/control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_rs_val    <= '0;
      r_rt_val    <= '0;
      r_imm       <= '0;
      r_use_imm   <= 1'b0;
      r_alu_op    <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else begin
      case (w_act)
        ACT_FLUSH, ACT_BUBBLE: begin
          r_valid     <= 1'b0;
          r_reg_write <= 1'b0;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
        end
        ACT_HOLD: begin
        end
        ACT_LOAD: begin
          r_valid     <= id_valid;
          r_rs        <= id_rs;
          r_rt        <= id_rt;
          r_rd        <= id_rd;
          r_rs_val    <= w_rs_cap;
          r_rt_val    <= w_rt_cap;
          r_imm       <= id_imm;
          r_use_imm   <= id_use_imm;
          r_alu_op    <= id_alu_op;
          r_reg_write <= id_reg_write && id_valid;
          r_mem_read  <= id_mem_read  && id_valid;
          r_mem_write <= id_mem_write && id_valid;
        end
      endcase
    end
  end

  // Operand forwarding; assigning EX/MEM last gives it priority over MEM/WB
  always_comb begin
    w_fwd_rs = r_rs_val;
    w_fwd_rt = r_rt_val;
    if (wb_reg_write  && (wb_rd  != '0) && (wb_rd  == r_rs)) w_fwd_rs = wb_result;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == r_rs)) w_fwd_rs = mem_result;
    if (wb_reg_write  && (wb_rd  != '0) && (wb_rd  == r_rt)) w_fwd_rt = wb_result;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == r_rt)) w_fwd_rt = mem_result;
  end

  assign ex_valid      = r_valid;
  assign ex_alu_op     = r_alu_op;
  assign ex_rd         = r_rd;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_data1      = w_fwd_rs;
  assign ex_data2      = r_use_imm ? r_imm : w_fwd_rt;
  assign ex_store_data = w_fwd_rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage with hand-computed expectations.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_val, id_rt_val, id_imm;
  logic        id_use_imm, id_use_rt;
  logic [2:0]  id_alu_op;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        flush, ex_hold;
  logic        mem_reg_write;
  logic [4:0]  mem_rd;
  logic [31:0] mem_result;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic        ex_valid;
  logic [2:0]  ex_alu_op;
  logic [31:0] ex_data1, ex_data2, ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic        stall_out;

  int unsigned n_tests;
  int unsigned n_fail;

  id_ex_stage u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rd         (id_rd),
    .id_rs_val     (id_rs_val),
    .id_rt_val     (id_rt_val),
    .id_imm        (id_imm),
    .id_use_imm    (id_use_imm),
    .id_use_rt     (id_use_rt),
    .id_alu_op     (id_alu_op),
    .id_reg_write  (id_reg_write),
    .id_mem_read   (id_mem_read),
    .id_mem_write  (id_mem_write),
    .flush         (flush),
    .ex_hold       (ex_hold),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_result     (wb_result),
    .ex_valid      (ex_valid),
    .ex_alu_op     (ex_alu_op),
    .ex_data1      (ex_data1),
    .ex_data2      (ex_data2),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .stall_out     (stall_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [31:0] rsv, input logic [31:0] rtv,
                        input logic [31:0] imm, input logic uimm, input logic urt,
                        input logic [2:0] op, input logic rw, input logic mr, input logic mw);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_val = rsv; id_rt_val = rtv; id_imm = imm;
    id_use_imm = uimm; id_use_rt = urt; id_alu_op = op;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic clr_fwd();
    mem_reg_write = 1'b0; mem_rd = '0; mem_result = '0;
    wb_reg_write = 1'b0; wb_rd = '0; wb_result = '0;
  endtask

  task automatic chk_empty(input string pfx);
    check({pfx, "_valid"},  {31'd0, ex_valid}, 32'd0);
    check({pfx, "_aluop"},  {29'd0, ex_alu_op}, 32'd0);
    check({pfx, "_rd"},     {27'd0, ex_rd}, 32'd0);
    check({pfx, "_ctrl"},   {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
    check({pfx, "_data1"},  ex_data1, 32'd0);
    check({pfx, "_data2"},  ex_data2, 32'd0);
    check({pfx, "_store"},  ex_store_data, 32'd0);
    check({pfx, "_stall"},  {31'd0, stall_out}, 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0; flush = 1'b0; ex_hold = 1'b0;
    clr_fwd();
    set_id(1, 5'd1, 5'd2, 5'd3, 32'h99, 32'h98, 32'h97, 0, 1, 3'd5, 1, 1, 1);
    #2;
    chk_empty("rst");
    step();
    chk_empty("rst_edge");
    rst_n = 1'b1;

    // basic add: rs=1 (5), rt=2 (7), rd=3
    set_id(1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 0, 1, 3'b000, 1, 0, 0);
    #1 check("add_stall", {31'd0, stall_out}, 32'd0);
    step();
    check("add_valid", {31'd0, ex_valid}, 32'd1);
    check("add_aluop", {29'd0, ex_alu_op}, 32'd0);
    check("add_data1", ex_data1, 32'd5);
    check("add_data2", ex_data2, 32'd7);
    check("add_rd",    {27'd0, ex_rd}, 32'd3);
    check("add_rw",    {31'd0, ex_reg_write}, 32'd1);

    // id_valid=0 masks control bits on load
    set_id(0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 0, 1, 3'b001, 1, 1, 1);
    step();
    check("inv_valid", {31'd0, ex_valid}, 32'd0);
    check("inv_ctrl",  {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);

    // capture-time WB bypass on both sources
    set_id(1, 5'd5, 5'd5, 5'd6, 32'hAAAA, 32'hBBBB, 32'd0, 0, 1, 3'b000, 1, 0, 0);
    wb_reg_write = 1'b1; wb_rd = 5'd5; wb_result = 32'h1234;
    step();
    clr_fwd();
    #1;
    check("cap_rs", ex_data1, 32'h1234);
    check("cap_rt", ex_store_data, 32'h1234);

    // EX-side forwarding priority and register-0 exclusion
    set_id(1, 5'd4, 5'd6, 5'd7, 32'h44, 32'h66, 32'd0, 0, 1, 3'b000, 1, 0, 0);
    step();
    mem_reg_write = 1'b1; mem_rd = 5'd4; mem_result = 32'h11;
    wb_reg_write  = 1'b1; wb_rd  = 5'd4; wb_result  = 32'h22;
    #1 check("fwd_mem_wins", ex_data1, 32'h11);
    mem_reg_write = 1'b0;
    #1 check("fwd_wb", ex_data1, 32'h22);
    mem_reg_write = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0;
    #1 check("fwd_r0", ex_data1, 32'h44);
    mem_rd = 5'd6; mem_result = 32'h5A5A;
    #1 check("fwd_rt_d2", ex_data2, 32'h5A5A);
    check("fwd_rt_st", ex_store_data, 32'h5A5A);
    check("fwd_rt_d1", ex_data1, 32'h44);
    clr_fwd();

    // load-use on rs: lw rd=8 then add rs=8
    set_id(1, 5'd1, 5'd2, 5'd8, 32'h10, 32'h20, 32'h4, 1, 0, 3'b000, 1, 1, 0);
    step();
    set_id(1, 5'd8, 5'd2, 5'd9, 32'h80, 32'h20, 32'h0, 0, 1, 3'b000, 1, 0, 0);
    #1 check("lu_stall", {31'd0, stall_out}, 32'd1);
    step();
    check("lu_bub_valid", {31'd0, ex_valid}, 32'd0);
    check("lu_bub_rw",    {31'd0, ex_reg_write}, 32'd0);
    check("lu_bub_mr",    {31'd0, ex_mem_read}, 32'd0);
    check("lu_bub_stall", {31'd0, stall_out}, 32'd0);
    step();
    check("lu_load_valid", {31'd0, ex_valid}, 32'd1);
    check("lu_load_rd",    {27'd0, ex_rd}, 32'd9);

    // load-use on rt: counted only when id_use_rt=1
    set_id(1, 5'd1, 5'd2, 5'd8, 32'h10, 32'h20, 32'h4, 1, 0, 3'b000, 1, 1, 0);
    step();
    set_id(1, 5'd1, 5'd8, 5'd9, 32'h10, 32'h80, 32'h0, 0, 0, 3'b000, 1, 0, 0);
    #1 check("lu_rt_unused", {31'd0, stall_out}, 32'd0);
    id_use_rt = 1'b1;
    #1 check("lu_rt_used", {31'd0, stall_out}, 32'd1);
    // flush overrides hazard
    flush = 1'b1;
    #1 check("lu_flush_stall", {31'd0, stall_out}, 32'd0);
    step();
    flush = 1'b0;
    check("lu_flush_valid", {31'd0, ex_valid}, 32'd0);

    // lw to r0 never causes a stall
    set_id(1, 5'd1, 5'd2, 5'd0, 32'h10, 32'h20, 32'h4, 1, 0, 3'b000, 1, 1, 0);
    step();
    set_id(1, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h0, 0, 1, 3'b000, 1, 0, 0);
    #1 check("lu_r0", {31'd0, stall_out}, 32'd0);

    // hold for 3 cycles with immediate operand
    set_id(1, 5'd3, 5'd7, 5'd10, 32'h33, 32'h77, 32'hFFFFFFFC, 1, 1, 3'b010, 0, 0, 1);
    step();
    ex_hold = 1'b1;
    set_id(1, 5'd12, 5'd13, 5'd11, 32'h1, 32'h2, 32'h3, 0, 1, 3'b111, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      #1 check("hold_stall", {31'd0, stall_out}, 32'd1);
      step();
      check("hold_valid", {31'd0, ex_valid}, 32'd1);
      check("hold_rd",    {27'd0, ex_rd}, 32'd10);
      check("hold_aluop", {29'd0, ex_alu_op}, 32'd2);
      check("hold_mw",    {31'd0, ex_mem_write}, 32'd1);
      check("hold_data2", ex_data2, 32'hFFFFFFFC);
      check("hold_store", ex_store_data, 32'h77);
    end
    mem_reg_write = 1'b1; mem_rd = 5'd7; mem_result = 32'hBEEF;
    #1 check("imm_d2",    ex_data2, 32'hFFFFFFFC);
    check("imm_store", ex_store_data, 32'hBEEF);
    check("imm_d1",    ex_data1, 32'h33);
    clr_fwd();
    ex_hold = 1'b0;
    step();
    check("unhold_rd", {27'd0, ex_rd}, 32'd11);
    check("unhold_ctrl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'b101);

    // flush and hold together on a valid stage
    flush = 1'b1; ex_hold = 1'b1;
    #1 check("fh_stall", {31'd0, stall_out}, 32'd0);
    step();
    check("fh_valid", {31'd0, ex_valid}, 32'd0);
    check("fh_ctrl",  {29'd0, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
    flush = 1'b0; ex_hold = 1'b0;

    // asynchronous reset between edges with a valid stage
    set_id(1, 5'd1, 5'd2, 5'd3, 32'h55, 32'h66, 32'h0, 0, 1, 3'b011, 1, 0, 1);
    step();
    check("ar_pre_valid", {31'd0, ex_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1 chk_empty("ar");
    #1 rst_n = 1'b1;
    #1 check("ar_rel_valid", {31'd0, ex_valid}, 32'd0);
    step();
    check("ar_first_valid", {31'd0, ex_valid}, 32'd1);
    check("ar_first_d1",    ex_data1, 32'h55);
    check("ar_first_aluop", {29'd0, ex_alu_op}, 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
